cr_ifu_lpmd_resp: RTL and testbench
===================================

// Module: cr_ifu_lpmd_resp
// PURPOSE
//   IFU-side responder for the low-power-mode entry handshake driven by cp0.
//   On cp0_ifu_lpmd_req: stops new fetch issue, drains outstanding bus fetches,
//   then returns ifu_cp0_lpmd_ack. Holds fetch masked while the core sleeps
//   and releases it on wake-up or flush. Sits between cp0 and the IFU bus request path.
// PARAMETERS
//   OUTSTD_MAX  2  max fetch transactions in flight on the bus (>=1)
//   CNT_W       2  counter width, must hold 0..OUTSTD_MAX
// PORTS
//   forever_cpuclk          in   1      ungated core clock
//   cpurst_b                in   1      async reset, active low
//   cp0_ifu_lpmd_req        in   1      lpmd entry request, level, held until ack seen
//   cp0_ifu_in_lpmd         in   1      core in low power (core or system view)
//   iu_yy_xx_flush          in   1      pipeline flush, abort any handshake
//   bmu_ifu_grnt            in   1      fetch request accepted by bus this cycle
//   bmu_ifu_trans_cmplt     in   1      one outstanding fetch completed this cycle
//   ifu_cp0_lpmd_ack        out  1      IFU quiescent, registered
//   lpmd_ifu_req_mask       out  1      block new fetch requests to the bus
//   lpmd_ifu_sleep          out  1      IFU asleep, fetch clock may be gated
//   lpmd_outstd_cnt         out  CNT_W  in-flight fetch count, debug/visibility
// BEHAVIOUR
// - Reset: state IDLE, outstd_cnt 0, ack 0, sleep 0, req_mask 0.
// - Counter: +1 on grnt, -1 on cmplt, both in the same cycle -> unchanged.
//   Runs in every state, including through flush (bus traffic still completes).
//   Saturates: grnt at OUTSTD_MAX holds; cmplt at 0 holds (both protocol errors, bench asserts).
// - cnt_zero_nxt = next-cycle counter value == 0.
// - FSM (forever_cpuclk; flush takes priority, forces IDLE next cycle from any state):
//   IDLE : req & cnt_zero_nxt -> ACK; req & !cnt_zero_nxt -> DRAIN; else IDLE.
//   DRAIN: !req -> IDLE; cnt_zero_nxt -> ACK; else DRAIN.
//   ACK  : req -> ACK; !req & in_lpmd -> SLEEP; !req & !in_lpmd -> IDLE (entry aborted).
//   SLEEP: !in_lpmd -> IDLE; else SLEEP.
// - ifu_cp0_lpmd_ack = (state==ACK); ack latency is 1 cycle after req when drained.
//   Ack stays high while req is held; deasserts the cycle after req drops.
// - lpmd_ifu_req_mask = cp0_ifu_lpmd_req | (state!=IDLE), combinational from req,
//   so no new grant can be requested in the cycle req rises. A grant already in
//   flight that cycle is counted and drained normally.
// - lpmd_ifu_sleep = (state==SLEEP), registered.
// - Simultaneous req rise and flush: flush wins, state stays IDLE, mask follows req only.
// - Wake (in_lpmd falls) coincident with req: SLEEP -> IDLE, then new entry from IDLE.
// - Reset mid-handshake: all outputs to reset values asynchronously; counter cleared
//   (bus side is reset together with the core).
// - Clock: not gated by this block; must observe in_lpmd/flush while asleep.
// STRUCTURE
// - Shared cp0/ifu lpmd package: state encodings IDLE=2'b00, DRAIN=2'b01,
//   ACK=2'b11, SLEEP=2'b10 (Gray-ordered entry path), OUTSTD_MAX default.
// - One sub-module: cr_ifu_lpmd_outstd_cnt (saturating up/down counter with
//   cnt_zero_nxt output); FSM and output decode stay in this module.
// TESTING
// - cnt=0, req rises at cycle 0 -> ack=1 at cycle 1; req drops with in_lpmd=1 ->
//   sleep=1 next cycle; in_lpmd falls -> sleep=0, mask=0 one cycle later.
// - 2 fetches in flight, req rises -> mask=1 same cycle, DRAIN; cmplt at cycles 3 and 5
//   -> ack=1 at cycle 6, never earlier.
// - grnt in same cycle req rises with cnt=0 -> cnt=1, DRAIN; cmplt -> ack next cycle.
// - Flush in DRAIN and in ACK -> state IDLE, ack=0 next cycle, cnt unaffected, later cmplt
//   still decrements to 0.
// - ACK then req drops with in_lpmd=0 (wake interrupt) -> IDLE, sleep never asserted.
// - Simultaneous grnt+cmplt at cnt=1 during DRAIN -> cnt stays 1, no ack; reset asserted
//   mid-SLEEP -> all outputs 0, cnt 0 immediately.

Source files
------------

// File: rtl/cr_ifu_lpmd_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module : cr_ifu_lpmd_resp_pkg
// Brief  : Shared cp0/IFU low-power-mode types and defaults.
// Rev    : 1.0  initial release
// ============================================================================
package cr_ifu_lpmd_resp_pkg;

    localparam int OUTSTD_MAX_DFLT = 2;
    localparam int CNT_W_DFLT      = 2;

    // Entry path IDLE->DRAIN->ACK->SLEEP changes one bit per step
    typedef enum logic [1:0] {
        LPMD_IDLE  = 2'b00,
        LPMD_DRAIN = 2'b01,
        LPMD_ACK   = 2'b11,
        LPMD_SLEEP = 2'b10
    } lpmd_state_e;

endpackage : cr_ifu_lpmd_resp_pkg
`default_nettype wire

// File: rtl/cr_ifu_lpmd_resp_if.sv
`default_nettype none
// ============================================================================
// Module : cr_ifu_lpmd_resp_if
// Brief  : cp0 / bus-side handshake bundle for the IFU lpmd responder.
// Rev    : 1.0  initial release
// ============================================================================
interface cr_ifu_lpmd_resp_if #(
    parameter int CNT_W = 2
);
    logic             cp0_ifu_lpmd_req;
    logic             cp0_ifu_in_lpmd;
    logic             iu_yy_xx_flush;
    logic             bmu_ifu_grnt;
    logic             bmu_ifu_trans_cmplt;
    logic             ifu_cp0_lpmd_ack;
    logic             lpmd_ifu_req_mask;
    logic             lpmd_ifu_sleep;
    logic [CNT_W-1:0] lpmd_outstd_cnt;

    modport slave (
        input  cp0_ifu_lpmd_req,
        input  cp0_ifu_in_lpmd,
        input  iu_yy_xx_flush,
        input  bmu_ifu_grnt,
        input  bmu_ifu_trans_cmplt,
        output ifu_cp0_lpmd_ack,
        output lpmd_ifu_req_mask,
        output lpmd_ifu_sleep,
        output lpmd_outstd_cnt
    );

    modport master (
        output cp0_ifu_lpmd_req,
        output cp0_ifu_in_lpmd,
        output iu_yy_xx_flush,
        output bmu_ifu_grnt,
        output bmu_ifu_trans_cmplt,
        input  ifu_cp0_lpmd_ack,
        input  lpmd_ifu_req_mask,
        input  lpmd_ifu_sleep,
        input  lpmd_outstd_cnt
    );

endinterface : cr_ifu_lpmd_resp_if
`default_nettype wire

// File: rtl/cr_ifu_lpmd_outstd_cnt.sv
`default_nettype none
// ============================================================================
// Module : cr_ifu_lpmd_outstd_cnt
// Brief  : Saturating in-flight fetch counter with next-value-zero lookahead.
// Rev    : 1.0  initial release
// ============================================================================
module cr_ifu_lpmd_outstd_cnt #(
    parameter int OUTSTD_MAX = 2,
    parameter int CNT_W      = 2
) (
    input  wire logic             forever_cpuclk,
    input  wire logic             cpurst_b,
    input  wire logic             grnt,
    input  wire logic             cmplt,
    output logic      [CNT_W-1:0] cnt,
    output logic                  cnt_zero_nxt
);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(OUTSTD_MAX);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Out-of-range steps are bus protocol errors; holding keeps the count sane
    always_comb begin
        cnt_d = cnt_q;
        if (grnt && !cmplt && (cnt_q != C_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (cmplt && !grnt && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt          = cnt_q;
    assign cnt_zero_nxt = (cnt_d == '0);

endmodule : cr_ifu_lpmd_outstd_cnt
`default_nettype wire

// File: rtl/cr_ifu_lpmd_resp.sv
`default_nettype none
// ============================================================================
// Module : cr_ifu_lpmd_resp
// Brief  : IFU responder for cp0 low-power entry: mask, drain, ack, sleep.
// Rev    : 1.0  initial release
// ============================================================================
module cr_ifu_lpmd_resp
    import cr_ifu_lpmd_resp_pkg::*;
#(
    parameter int OUTSTD_MAX = OUTSTD_MAX_DFLT,
    parameter int CNT_W      = CNT_W_DFLT
) (
    input  wire logic          forever_cpuclk,
    input  wire logic          cpurst_b,
    cr_ifu_lpmd_resp_if.slave  lpmd_if
);

    lpmd_state_e      state_d;
    lpmd_state_e      state_q;
    logic             ack_d;
    logic             ack_q;
    logic             sleep_d;
    logic             sleep_q;
    logic [CNT_W-1:0] outstd_cnt;
    logic             cnt_zero_nxt;
    logic             req;
    logic             in_lpmd;

    assign req     = lpmd_if.cp0_ifu_lpmd_req;
    assign in_lpmd = lpmd_if.cp0_ifu_in_lpmd;

    cr_ifu_lpmd_outstd_cnt #(
        .OUTSTD_MAX (OUTSTD_MAX),
        .CNT_W      (CNT_W)
    ) u_outstd_cnt (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .grnt           (lpmd_if.bmu_ifu_grnt),
        .cmplt          (lpmd_if.bmu_ifu_trans_cmplt),
        .cnt            (outstd_cnt),
        .cnt_zero_nxt   (cnt_zero_nxt)
    );

    always_comb begin
        state_d = state_q;
        if (lpmd_if.iu_yy_xx_flush) begin
            state_d = LPMD_IDLE;
        end else begin
            case (state_q)
                LPMD_IDLE: begin
                    if (req) state_d = cnt_zero_nxt ? LPMD_ACK : LPMD_DRAIN;
                end
                LPMD_DRAIN: begin
                    if (!req)              state_d = LPMD_IDLE;
                    else if (cnt_zero_nxt) state_d = LPMD_ACK;
                end
                LPMD_ACK: begin
                    // cp0 dropping req without entering lpmd means a wake-up aborted entry
                    if (!req) state_d = in_lpmd ? LPMD_SLEEP : LPMD_IDLE;
                end
                LPMD_SLEEP: begin
                    if (!in_lpmd) state_d = LPMD_IDLE;
                end
                default: state_d = LPMD_IDLE;
            endcase
        end
        ack_d   = (state_d == LPMD_ACK);
        sleep_d = (state_d == LPMD_SLEEP);
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= LPMD_IDLE;
            ack_q   <= 1'b0;
            sleep_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            sleep_q <= sleep_d;
        end
    end

    // Raw req in the mask closes the window in the cycle req first rises
    assign lpmd_if.lpmd_ifu_req_mask = req | (state_q != LPMD_IDLE);
    assign lpmd_if.ifu_cp0_lpmd_ack  = ack_q;
    assign lpmd_if.lpmd_ifu_sleep    = sleep_q;
    assign lpmd_if.lpmd_outstd_cnt   = outstd_cnt;

endmodule : cr_ifu_lpmd_resp
`default_nettype wire

// File: tb/tb_cr_ifu_lpmd_resp.sv
`default_nettype none
// ============================================================================
// Module : tb_cr_ifu_lpmd_resp
// Brief  : Directed scoreboard bench for the IFU lpmd responder.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cr_ifu_lpmd_resp;

    typedef struct {
        int         cyc;
        string      name;
        logic       ack;
        logic       mask;
        logic       sleep;
        logic [1:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    exp_t sb_q[$];

    cr_ifu_lpmd_resp_if #(.CNT_W(2)) lpmd_if ();

    cr_ifu_lpmd_resp #(
        .OUTSTD_MAX (2),
        .CNT_W      (2)
    ) dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .lpmd_if        (lpmd_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Inputs are driven 1ns after a rising edge; outputs sampled at the falling edge
    task automatic step(input logic rst, input logic req, input logic lp,
                        input logic fl, input logic g, input logic c,
                        input logic e_ack, input logic e_mask,
                        input logic e_sleep, input logic [1:0] e_cnt,
                        input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n                       = rst;
        lpmd_if.cp0_ifu_lpmd_req    = req;
        lpmd_if.cp0_ifu_in_lpmd     = lp;
        lpmd_if.iu_yy_xx_flush      = fl;
        lpmd_if.bmu_ifu_grnt        = g;
        lpmd_if.bmu_ifu_trans_cmplt = c;
        e.cyc   = cyc;
        e.name  = name;
        e.ack   = e_ack;
        e.mask  = e_mask;
        e.sleep = e_sleep;
        e.cnt   = e_cnt;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            n_cmp = n_cmp + 1;
            if (lpmd_if.ifu_cp0_lpmd_ack  !== e.ack  ||
                lpmd_if.lpmd_ifu_req_mask !== e.mask ||
                lpmd_if.lpmd_ifu_sleep    !== e.sleep ||
                lpmd_if.lpmd_outstd_cnt   !== e.cnt) begin
                n_bad = n_bad + 1;
                $display("FAIL %s @cyc%0d: got ack=%b mask=%b sleep=%b cnt=%0d, want ack=%b mask=%b sleep=%b cnt=%0d",
                         e.name, e.cyc, lpmd_if.ifu_cp0_lpmd_ack, lpmd_if.lpmd_ifu_req_mask,
                         lpmd_if.lpmd_ifu_sleep, lpmd_if.lpmd_outstd_cnt,
                         e.ack, e.mask, e.sleep, e.cnt);
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        lpmd_if.cp0_ifu_lpmd_req    = 1'b0;
        lpmd_if.cp0_ifu_in_lpmd     = 1'b0;
        lpmd_if.iu_yy_xx_flush      = 1'b0;
        lpmd_if.bmu_ifu_grnt        = 1'b0;
        lpmd_if.bmu_ifu_trans_cmplt = 1'b0;

        //   rst req lp fl g c    ack msk slp cnt
        step(0, 0, 0, 0, 0, 0,   0, 0, 0, 2'd0, "reset");
        step(1, 0, 0, 0, 0, 0,   0, 0, 0, 2'd0, "reset_release");
        // drained entry, sleep, wake
        step(1, 1, 0, 0, 0, 0,   0, 1, 0, 2'd0, "req_rise_mask");
        step(1, 1, 0, 0, 0, 0,   1, 1, 0, 2'd0, "ack_latency1");
        step(1, 0, 1, 0, 0, 0,   1, 1, 0, 2'd0, "ack_req_drop");
        step(1, 0, 1, 0, 0, 0,   0, 1, 1, 2'd0, "sleep_set");
        step(1, 0, 0, 0, 0, 0,   0, 1, 1, 2'd0, "wake_edge");
        step(1, 0, 0, 0, 0, 0,   0, 0, 0, 2'd0, "wake_released");
        // two fetches in flight, drain
        step(1, 0, 0, 0, 1, 0,   0, 0, 0, 2'd0, "grnt1");
        step(1, 0, 0, 0, 1, 0,   0, 0, 0, 2'd1, "grnt2");
        step(1, 1, 0, 0, 0, 0,   0, 1, 0, 2'd2, "drain_c0");
        step(1, 1, 0, 0, 0, 0,   0, 1, 0, 2'd2, "drain_c1");
        step(1, 1, 0, 0, 0, 0,   0, 1, 0, 2'd2, "drain_c2");
        step(1, 1, 0, 0, 0, 1,   0, 1, 0, 2'd2, "drain_c3_cmplt");
        step(1, 1, 0, 0, 0, 0,   0, 1, 0, 2'd1, "drain_c4");
        step(1, 1, 0, 0, 0, 1,   0, 1, 0, 2'd1, "drain_c5_cmplt");
        step(1, 1, 0, 0, 0, 0,   1, 1, 0, 2'd0, "drain_c6_ack");
        // wake interrupt aborts entry from ACK
        step(1, 0, 0, 0, 0, 0,   1, 1, 0, 2'd0, "abort_req_drop");
        step(1, 0, 0, 0, 0, 0,   0, 0, 0, 2'd0, "abort_idle");
        // grant coincident with req rise
        step(1, 1, 0, 0, 1, 0,   0, 1, 0, 2'd0, "req_grnt_same");
        step(1, 1, 0, 0, 0, 0,   0, 1, 0, 2'd1, "req_grnt_drain");
        step(1, 1, 0, 0, 0, 1,   0, 1, 0, 2'd1, "req_grnt_cmplt");
        step(1, 1, 0, 0, 0, 0,   1, 1, 0, 2'd0, "req_grnt_ack");
        // flush in ACK
        step(1, 1, 0, 1, 0, 0,   1, 1, 0, 2'd0, "flush_in_ack");
        step(1, 0, 0, 0, 0, 0,   0, 0, 0, 2'd0, "flush_ack_idle");
        // flush in DRAIN, count survives
        step(1, 0, 0, 0, 1, 0,   0, 0, 0, 2'd0, "fd_grnt");
        step(1, 1, 0, 0, 0, 0,   0, 1, 0, 2'd1, "fd_req");
        step(1, 1, 0, 1, 0, 0,   0, 1, 0, 2'd1, "flush_in_drain");
        step(1, 0, 0, 0, 0, 0,   0, 0, 0, 2'd1, "fd_idle_cnt_kept");
        step(1, 0, 0, 0, 0, 1,   0, 0, 0, 2'd1, "fd_late_cmplt");
        step(1, 0, 0, 0, 0, 0,   0, 0, 0, 2'd0, "fd_cnt_zero");
        // req rise with flush
        step(1, 1, 0, 1, 0, 0,   0, 1, 0, 2'd0, "req_flush_same");
        step(1, 0, 0, 0, 0, 0,   0, 0, 0, 2'd0, "req_flush_idle");
        // grnt+cmplt together at cnt=1 in DRAIN
        step(1, 0, 0, 0, 1, 0,   0, 0, 0, 2'd0, "gc_grnt");
        step(1, 1, 0, 0, 0, 0,   0, 1, 0, 2'd1, "gc_req");
        step(1, 1, 0, 0, 1, 1,   0, 1, 0, 2'd1, "gc_both");
        step(1, 1, 0, 0, 0, 0,   0, 1, 0, 2'd1, "gc_no_ack");
        step(1, 1, 0, 0, 0, 1,   0, 1, 0, 2'd1, "gc_cmplt");
        step(1, 1, 0, 0, 0, 0,   1, 1, 0, 2'd0, "gc_ack");
        step(1, 0, 1, 0, 0, 0,   1, 1, 0, 2'd0, "gc_req_drop");
        step(1, 0, 1, 0, 0, 0,   0, 1, 1, 2'd0, "gc_sleep");
        // async reset while asleep
        step(0, 0, 1, 0, 0, 0,   0, 0, 0, 2'd0, "reset_in_sleep");
        step(1, 0, 1, 0, 0, 0,   0, 0, 0, 2'd0, "reset_in_sleep_rel");
        // wake coincident with req
        step(1, 1, 0, 0, 0, 0,   0, 1, 0, 2'd0, "wr_req");
        step(1, 1, 1, 0, 0, 0,   1, 1, 0, 2'd0, "wr_ack");
        step(1, 0, 1, 0, 0, 0,   1, 1, 0, 2'd0, "wr_req_drop");
        step(1, 1, 0, 0, 0, 0,   0, 1, 1, 2'd0, "wr_wake_and_req");
        step(1, 1, 0, 0, 0, 0,   0, 1, 0, 2'd0, "wr_idle_reentry");
        step(1, 1, 0, 0, 0, 0,   1, 1, 0, 2'd0, "wr_ack_again");
        step(1, 0, 0, 0, 0, 0,   1, 1, 0, 2'd0, "wr_abort");
        step(1, 0, 0, 0, 0, 0,   0, 0, 0, 2'd0, "wr_idle");
        // req withdrawn during DRAIN
        step(1, 0, 0, 0, 1, 0,   0, 0, 0, 2'd0, "wd_grnt");
        step(1, 1, 0, 0, 0, 0,   0, 1, 0, 2'd1, "wd_req");
        step(1, 0, 0, 0, 0, 0,   0, 1, 0, 2'd1, "wd_req_drop");
        step(1, 0, 0, 0, 0, 1,   0, 0, 0, 2'd1, "wd_idle_cmplt");
        step(1, 0, 0, 0, 0, 0,   0, 0, 0, 2'd0, "wd_final");

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: timeout at cycle %0d, want completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule : tb_cr_ifu_lpmd_resp
`default_nettype wire
